onchip_write_master_result: RTL and testbench

ONCHIP_WRITE_MASTER_RESULT -- requirements
Module: onchip_write_master_result

---
 rtl/onchip_write_master_result.sv | 218 +++++++++++++++++++++
 tb/tb_onchip_write_master_result.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/onchip_write_master_result.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : onchip_write_master_result
// Description : Avalon-MM write master that drains result words from the PE
//               array into on-chip memory. A control-side start request
//               latches a base word address and a word count; words arrive
//               through a 2-entry input FIFO and are written to base+k.
// Ports       :
//   clk, rst                  single clock, synchronous active-high reset
//   addr_write, data_write,   Avalon-MM write channel (word addressed)
//   byteenable, write,
//   chipselect, wait_request
//   start, addr_write_input,  control: transfer request with base / length
//   len_input, busy, done
//   data_in, data_in_valid,   PE-array result stream (valid/ready)
//   data_in_ready
//   data_in_mask              per-word byte mask (only with
//                             WRITE_MASTER_BYTEMASK_EN defined)
// Options     : `define WRITE_MASTER_BYTEMASK_EN to carry a byte mask with
//               each word; otherwise byteenable is all-ones.
// Revision    : 1.0  initial release
// ============================================================================
module onchip_write_master_result #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 1024,
  parameter int LEN_W  = 12
) (
  input  logic                clk,
  input  logic                rst,
  // Avalon-MM master
  output logic [ADDR_W-1:0]   addr_write,
  output logic [DATA_W-1:0]   data_write,
  output logic [DATA_W/8-1:0] byteenable,
  output logic                write,
  output logic                chipselect,
  input  logic                wait_request,
  // control
  input  logic                start,
  input  logic [ADDR_W-1:0]   addr_write_input,
  input  logic [LEN_W-1:0]    len_input,
  output logic                busy,
  output logic                done,
  // PE array
  input  logic [DATA_W-1:0]   data_in,
`ifdef WRITE_MASTER_BYTEMASK_EN
  input  logic [DATA_W/8-1:0] data_in_mask,
`endif
  input  logic                data_in_valid,
  output logic                data_in_ready
);

  localparam int C_BE_W = DATA_W / 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t state, state_next;

  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]  r_len;        // words to take from the PE array
  logic [LEN_W-1:0]  r_taken;      // words taken so far
  logic [LEN_W-1:0]  r_remaining;  // words not yet accepted by the slave

  // Two-entry FIFO kept as a head/tail pair so the head register feeds
  // data_write directly and stays stable while the slave stalls.
  logic [DATA_W-1:0] r_slot0;
  logic [DATA_W-1:0] r_slot1;
  logic [1:0]        r_fifo_cnt;

  logic w_accept;
  logic w_push;
  logic w_push_to_head;

  assign w_accept = write & ~wait_request;
  assign w_push   = data_in_valid & data_in_ready;
  // A push lands in the head slot when the FIFO is empty, or when it holds
  // one word that is leaving this very cycle.
  assign w_push_to_head = (r_fifo_cnt == 2'd0) || ((r_fifo_cnt == 2'd1) && w_accept);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and control outputs
  // --------------------------------------------------------------------------
  always_comb begin
    state_next    = state;
    busy          = 1'b0;
    done          = 1'b0;
    write         = 1'b0;
    data_in_ready = 1'b0;
    case (state)
      S_IDLE: begin
        // A zero-length request also passes through WRITE for one cycle, so
        // done always follows start by two cycles and busy is held for two.
        if (start) begin
          state_next = S_WRITE;
        end
      end
      S_WRITE: begin
        busy          = 1'b1;
        write         = (r_fifo_cnt != 2'd0);
        // Ready is withheld on a full FIFO even if a pop is in flight.
        data_in_ready = (r_fifo_cnt != 2'd2) && (r_taken != r_len);
        if (r_remaining == '0) begin
          state_next = S_DONE;
        end else if (write && !wait_request && (r_remaining == LEN_W'(1))) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign chipselect = write;
  assign addr_write = r_addr;
  assign data_write = r_slot0;

  // --------------------------------------------------------------------------
  // Address, counters and FIFO data
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr      <= '0;
      r_len       <= '0;
      r_taken     <= '0;
      r_remaining <= '0;
      r_slot0     <= '0;
      r_slot1     <= '0;
      r_fifo_cnt  <= 2'd0;
    end else begin
      if ((state == S_IDLE) && start) begin
        r_addr      <= addr_write_input;
        r_len       <= len_input;
        r_remaining <= len_input;
        r_taken     <= '0;
      end

      if (w_accept) begin
        r_addr      <= r_addr + ADDR_W'(1);   // wraps modulo 2^ADDR_W
        r_remaining <= r_remaining - LEN_W'(1);
      end

      if (w_push) begin
        r_taken <= r_taken + LEN_W'(1);
      end

      if (w_accept && (r_fifo_cnt == 2'd2)) begin
        r_slot0 <= r_slot1;
      end
      if (w_push) begin
        if (w_push_to_head) begin
          r_slot0 <= data_in;
        end else begin
          r_slot1 <= data_in;
        end
      end

      case ({w_push, w_accept})
        2'b10:   r_fifo_cnt <= r_fifo_cnt + 2'd1;
        2'b01:   r_fifo_cnt <= r_fifo_cnt - 2'd1;
        default: r_fifo_cnt <= r_fifo_cnt;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Byte enables
  // --------------------------------------------------------------------------
`ifdef WRITE_MASTER_BYTEMASK_EN
  logic [C_BE_W-1:0] r_mask0;
  logic [C_BE_W-1:0] r_mask1;

  // The mask travels through the FIFO in lockstep with its data word.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mask0 <= '0;
      r_mask1 <= '0;
    end else begin
      if (w_accept && (r_fifo_cnt == 2'd2)) begin
        r_mask0 <= r_mask1;
      end
      if (w_push) begin
        if (w_push_to_head) begin
          r_mask0 <= data_in_mask;
        end else begin
          r_mask1 <= data_in_mask;
        end
      end
    end
  end

  assign byteenable = r_mask0;
`else
  assign byteenable = {C_BE_W{1'b1}};
`endif

endmodule
`default_nettype wire

// File: tb/tb_onchip_write_master_result.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_onchip_write_master_result
// Description : Directed self-checking bench for onchip_write_master_result.
//               Covers reset state, a plain 4-word burst, a slave stall on
//               the second word, address wrap, zero length with an ignored
//               start, mid-transfer reset and byte enables.
// Revision    : 1.0  initial release
// ============================================================================
module tb_onchip_write_master_result;

  localparam int ADDR_W = 17;
  localparam int DATA_W = 64;
  localparam int LEN_W  = 12;
  localparam int BE_W   = DATA_W / 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] addr_write;
  logic [DATA_W-1:0] data_write;
  logic [BE_W-1:0]   byteenable;
  logic              write;
  logic              chipselect;
  logic              wait_request = 1'b0;
  logic              start;
  logic [ADDR_W-1:0] addr_write_input;
  logic [LEN_W-1:0]  len_input;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] data_in;
  logic              data_in_valid;
  logic              data_in_ready;
  logic [15:0]       tag;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int taken_cnt = 0;

`ifdef WRITE_MASTER_BYTEMASK_EN
  int              mask_idx = -1;
  logic [BE_W-1:0] data_in_mask;
  assign data_in_mask = (taken_cnt == mask_idx) ? 8'h0F : 8'hFF;
`endif

  onchip_write_master_result #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .LEN_W (LEN_W)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .addr_write      (addr_write),
    .data_write      (data_write),
    .byteenable      (byteenable),
    .write           (write),
    .chipselect      (chipselect),
    .wait_request    (wait_request),
    .start           (start),
    .addr_write_input(addr_write_input),
    .len_input       (len_input),
    .busy            (busy),
    .done            (done),
    .data_in         (data_in),
`ifdef WRITE_MASTER_BYTEMASK_EN
    .data_in_mask    (data_in_mask),
`endif
    .data_in_valid   (data_in_valid),
    .data_in_ready   (data_in_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // PE-array source: each word carries the running handshake count.
  always @(posedge clk) begin
    if (data_in_valid && data_in_ready) taken_cnt <= taken_cnt + 1;
  end
  assign data_in = {tag, 32'h5A5A_0000, taken_cnt[15:0]};

  function automatic logic [63:0] exp_word(input logic [15:0] tg, input int idx);
    logic [31:0] v;
    v = idx;
    return {tg, 32'h5A5A_0000, v[15:0]};
  endfunction

  // Slave model and bus logger, evaluated on the falling edge.
  int              stall_req  = 0;
  int              stall_used = 0;
  logic [ADDR_W-1:0] stall_at = '0;
  int              ready_low_in_stall = 0;
  logic [63:0]     acc_addr[$];
  logic [63:0]     acc_data[$];
  logic [63:0]     acc_be[$];
  int              acc_cyc[$];
  logic [63:0]     stall_addr[$];
  logic [63:0]     stall_data[$];
  int              done_cyc[$];

  always @(negedge clk) begin
    if ((stall_used < stall_req) && write && (addr_write == stall_at)) begin
      wait_request = 1'b1;
      stall_used   = stall_used + 1;
    end else begin
      wait_request = 1'b0;
    end
    if (write && !wait_request) begin
      acc_addr.push_back(64'(addr_write));
      acc_data.push_back(64'(data_write));
      acc_be.push_back(64'(byteenable));
      acc_cyc.push_back(cyc);
    end
    if (write && wait_request) begin
      stall_addr.push_back(64'(addr_write));
      stall_data.push_back(64'(data_write));
      if (!data_in_ready) ready_low_in_stall = ready_low_in_stall + 1;
    end
    if (done) done_cyc.push_back(cyc);
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total = total + 1;
    if (got !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  int s_cyc;

  task automatic do_start(input logic [ADDR_W-1:0] base, input logic [LEN_W-1:0] len);
    addr_write_input = base;
    len_input        = len;
    start            = 1'b1;
    tick();
    start            = 1'b0;
    s_cyc            = cyc;
  endtask

  task automatic wait_done(input int n0);
    int k;
    k = 0;
    while ((done_cyc.size() <= n0) && (k < 40)) begin
      tick();
      k++;
    end
    check("done_timeout", 64'(done_cyc.size() > n0), 64'd1);
    tick();
    tick();
  endtask

  initial begin
    int a0, d0, t0, r0;
    rst = 1'b1; start = 1'b0; addr_write_input = '0; len_input = '0;
    data_in_valid = 1'b1; tag = 16'h0000;
    tick(); tick();
    check("rst_write", 64'(write), 64'd0);
    check("rst_cs", 64'(chipselect), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_ready", 64'(data_in_ready), 64'd0);
    check("rst_addr", 64'(addr_write), 64'd0);
    check("rst_data", 64'(data_write), 64'd0);
    rst = 1'b0;
    tick();

    // 4-word burst, no stall
    tag = 16'h1111; a0 = acc_addr.size(); d0 = done_cyc.size(); t0 = taken_cnt;
`ifdef WRITE_MASTER_BYTEMASK_EN
    mask_idx = t0;
`endif
    do_start(17'h00010, 12'd4);
    wait_done(d0);
    check("b1_count", 64'(acc_addr.size() - a0), 64'd4);
    for (int k = 0; k < 4; k++) begin
      if (a0 + k < acc_addr.size()) begin
        check("b1_addr", acc_addr[a0+k], 64'h10 + 64'(k));
        check("b1_data", acc_data[a0+k], exp_word(tag, t0 + k));
        check("b1_cyc", 64'(acc_cyc[a0+k]), 64'(s_cyc + 1 + k));
      end
    end
`ifdef WRITE_MASTER_BYTEMASK_EN
    check("b1_be0", acc_be[a0], 64'h0F);
`else
    check("b1_be0", acc_be[a0], 64'hFF);
`endif
    check("b1_be1", acc_be[a0+1], 64'hFF);
    check("b1_done_cyc", 64'(done_cyc[d0]), 64'(s_cyc + 5));
    check("b1_taken", 64'(taken_cnt - t0), 64'd4);

    // same burst, slave stalls 3 cycles on the second word
    tag = 16'h2222; a0 = acc_addr.size(); d0 = done_cyc.size(); t0 = taken_cnt;
    r0 = stall_addr.size();
    stall_at = 17'h00011; stall_req = stall_used + 3;
    do_start(17'h00010, 12'd4);
    wait_done(d0);
    check("st_count", 64'(acc_addr.size() - a0), 64'd4);
    for (int k = 0; k < 4; k++) begin
      if (a0 + k < acc_addr.size()) begin
        check("st_addr", acc_addr[a0+k], 64'h10 + 64'(k));
        check("st_data", acc_data[a0+k], exp_word(tag, t0 + k));
      end
    end
    check("st_stalls", 64'(stall_addr.size() - r0), 64'd3);
    for (int k = r0; k < stall_addr.size(); k++) begin
      check("st_hold_addr", stall_addr[k], 64'h11);
      check("st_hold_data", stall_data[k], exp_word(tag, t0 + 1));
    end
    check("st_ready_low", 64'(ready_low_in_stall), 64'd2);
    check("st_acc1_cyc", 64'(acc_cyc[a0+1]), 64'(s_cyc + 5));
    check("st_done_cyc", 64'(done_cyc[d0]), 64'(s_cyc + 8));
    check("st_taken", 64'(taken_cnt - t0), 64'd4);

    // address wrap
    tag = 16'h3333; a0 = acc_addr.size(); d0 = done_cyc.size(); t0 = taken_cnt;
    do_start(17'h1FFFF, 12'd2);
    wait_done(d0);
    check("wr_count", 64'(acc_addr.size() - a0), 64'd2);
    check("wr_addr0", acc_addr[a0], 64'h1FFFF);
    check("wr_addr1", acc_addr[a0+1], 64'h00000);
    check("wr_data1", acc_data[a0+1], exp_word(tag, t0 + 1));
    check("wr_taken", 64'(taken_cnt - t0), 64'd2);

    // zero length, plus a start during busy that must be ignored
    tag = 16'h4444; a0 = acc_addr.size(); d0 = done_cyc.size(); t0 = taken_cnt;
    do_start(17'h00030, 12'd0);
    check("z_busy1", 64'(busy), 64'd1);
    check("z_done1", 64'(done), 64'd0);
    check("z_write1", 64'(write), 64'd0);
    addr_write_input = 17'h00040; len_input = 12'd3; start = 1'b1;
    tick();
    start = 1'b0;
    check("z_busy2", 64'(busy), 64'd1);
    check("z_done2", 64'(done), 64'd1);
    tick();
    check("z_busy3", 64'(busy), 64'd0);
    check("z_done3", 64'(done), 64'd0);
    for (int k = 0; k < 6; k++) tick();
    check("z_no_write", 64'(acc_addr.size() - a0), 64'd0);
    check("z_one_done", 64'(done_cyc.size() - d0), 64'd1);
    check("z_done_cyc", 64'(done_cyc[d0]), 64'(s_cyc + 1));
    check("z_taken", 64'(taken_cnt - t0), 64'd0);

    // reset in the middle of a 6-word transfer
    tag = 16'h5555; a0 = acc_addr.size(); d0 = done_cyc.size();
    do_start(17'h00020, 12'd6);
    for (int k = 0; k < 30; k++) begin
      if (acc_addr.size() >= a0 + 2) break;
      tick();
    end
    check("rs_progress", 64'(acc_addr.size() >= a0 + 2), 64'd1);
    rst = 1'b1;
    tick();
    check("rs_write", 64'(write), 64'd0);
    check("rs_busy", 64'(busy), 64'd0);
    check("rs_ready", 64'(data_in_ready), 64'd0);
    check("rs_addr", 64'(addr_write), 64'd0);
    check("rs_data", 64'(data_write), 64'd0);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    check("rs_no_done", 64'(done_cyc.size() - d0), 64'd0);

    tag = 16'h6666; a0 = acc_addr.size(); d0 = done_cyc.size(); t0 = taken_cnt;
    do_start(17'h00055, 12'd1);
    wait_done(d0);
    check("rs1_count", 64'(acc_addr.size() - a0), 64'd1);
    check("rs1_addr", acc_addr[a0], 64'h55);
    check("rs1_data", acc_data[a0], exp_word(tag, t0));
    check("rs1_done_cyc", 64'(done_cyc[d0]), 64'(s_cyc + 2));
    check("rs1_taken", 64'(taken_cnt - t0), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
